// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex: the master side produces and
// consumes words, the slave side is the FIFO itself.
interface sync_fifo_flex_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  rd_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, data_i, rd_en, clr_err,
      input  data_o, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_i, rd_en, clr_err,
      output data_o, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels, live
// occupancy, sticky overflow/underflow flags and registered or FWFT read.
module sync_fifo_flex #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input logic              clk,
   input logic              rst_n,
   sync_fifo_flex_if.slave  bus
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0] ONE_C   = CW'(1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_r;
   logic [ADDR_WIDTH:0]   rd_ptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH:0]   count_next_s;
   logic                  full_r;
   logic                  empty_r;
   logic                  almost_full_r;
   logic                  almost_empty_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  wr_acc_s;
   logic                  rd_acc_s;

   // Acceptance uses the pre-edge flags, so a full FIFO never takes a write
   assign wr_acc_s = bus.wr_en && !full_r;
   assign rd_acc_s = bus.rd_en && !empty_r;

   // Next occupancy from the accepted requests
   always_comb begin
      count_next_s = count_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_next_s = count_r + ONE_C;
         2'b01:   count_next_s = count_r - ONE_C;
         default: count_next_s = count_r;
      endcase
   end

   // Pointers, occupancy and status flags registered from the next count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r       <= {CW{1'b0}};
         rd_ptr_r       <= {CW{1'b0}};
         count_r        <= {CW{1'b0}};
         full_r         <= 1'b0;
         empty_r        <= 1'b1;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else begin
         if (wr_acc_s) wr_ptr_r <= wr_ptr_r + ONE_C;
         if (rd_acc_s) rd_ptr_r <= rd_ptr_r + ONE_C;
         count_r        <= count_next_s;
         full_r         <= (count_next_s == DEPTH_C);
         empty_r        <= (count_next_s == {CW{1'b0}});
         almost_full_r  <= (count_next_s >= AF_C);
         almost_empty_r <= (count_next_s <= AE_C);
      end
   end

   // Sticky error flags; a new rejected request outranks a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (bus.wr_en && full_r)   overflow_r <= 1'b1;
         else if (bus.clr_err)      overflow_r <= 1'b0;
         if (bus.rd_en && empty_r)  underflow_r <= 1'b1;
         else if (bus.clr_err)      underflow_r <= 1'b0;
      end
   end

   // Storage write; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc_s) mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= bus.data_i;
   end

   generate
      if (FWFT == 0) begin : g_reg
         logic [DATA_WIDTH-1:0] data_r;
         logic                  rd_valid_r;

         // Registered read port: word appears the edge after acceptance
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_r     <= {DATA_WIDTH{1'b0}};
               rd_valid_r <= 1'b0;
            end else begin
               rd_valid_r <= rd_acc_s;
               if (rd_acc_s) data_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
            end
         end

         assign bus.data_o   = data_r;
         assign bus.rd_valid = rd_valid_r;
      end else begin : g_fwft
         // Head word shown directly; forced to zero while empty so no stale data leaks
         assign bus.data_o   = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
         assign bus.rd_valid = !empty_r;
      end
   endgenerate

   assign bus.full         = full_r;
   assign bus.empty        = empty_r;
   assign bus.almost_full  = almost_full_r;
   assign bus.almost_empty = almost_empty_r;
   assign bus.count        = count_r;
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// compares both against a queue model every cycle, plus directed literal checks.
module tb_sync_fifo_flex;
   localparam int DW = 8;
   localparam int DEPTH = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr_en = 1'b0;
   logic rd_en = 1'b0;
   logic clr_err = 1'b0;
   logic [DW-1:0] data_i = 8'h00;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
   sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

   assign if0.wr_en = wr_en;  assign if0.rd_en = rd_en;
   assign if0.data_i = data_i; assign if0.clr_err = clr_err;
   assign if1.wr_en = wr_en;  assign if1.rd_en = rd_en;
   assign if1.data_i = data_i; assign if1.clr_err = clr_err;

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                    .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                    .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   // Reference model: a queue of stored words plus the error and read-port state
   logic [DW-1:0] q[$];
   logic m_ovf = 1'b0, m_udf = 1'b0, m_v0 = 1'b0;
   logic [DW-1:0] m_d0 = 8'h00;
   int m_n;
   bit m_wa, m_ra;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_v0 = 1'b0; m_d0 = 8'h00;
      end else begin
         m_n  = q.size();
         m_wa = wr_en && (m_n < DEPTH);
         m_ra = rd_en && (m_n > 0);
         m_ovf = (wr_en && m_n == DEPTH) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
         m_udf = (rd_en && m_n == 0)     ? 1'b1 : (clr_err ? 1'b0 : m_udf);
         m_v0 = m_ra;
         if (m_ra) m_d0 = q.pop_front();
         if (m_wa) q.push_back(data_i);
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      int n;
      n = q.size();
      chk("count",        32'(if0.count),        32'(n));
      chk("full",         32'(if0.full),         32'(n == DEPTH));
      chk("empty",        32'(if0.empty),        32'(n == 0));
      chk("almost_full",  32'(if0.almost_full),  32'(n >= 6));
      chk("almost_empty", 32'(if0.almost_empty), 32'(n <= 2));
      chk("overflow",     32'(if0.overflow),     32'(m_ovf));
      chk("underflow",    32'(if0.underflow),    32'(m_udf));
      chk("rd_valid0",    32'(if0.rd_valid),     32'(m_v0));
      chk("data_o0",      32'(if0.data_o),       32'(m_d0));
      chk("count1",       32'(if1.count),        32'(n));
      chk("overflow1",    32'(if1.overflow),     32'(m_ovf));
      chk("underflow1",   32'(if1.underflow),    32'(m_udf));
      chk("rd_valid1",    32'(if1.rd_valid),     32'(n > 0));
      chk("data_o1",      32'(if1.data_o),       32'((n > 0) ? q[0] : 8'h00));
   end

   task automatic cyc(input logic we, input logic [DW-1:0] d, input logic re, input logic clr);
      wr_en = we; data_i = d; rd_en = re; clr_err = clr;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DW-1:0] exp5 [14];
      #22 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_empty", 32'(if0.empty), 32'd1);
      chk("rst_ae",    32'(if0.almost_empty), 32'd1);

      // Fill, almost_full from count 6, then overflow
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         chk("fill_count", 32'(if0.count), 32'(i + 1));
         chk("fill_af",    32'(if0.almost_full), 32'(i + 1 >= 6));
      end
      chk("full", 32'(if0.full), 32'd1);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ovf_set",   32'(if0.overflow), 32'd1);
      chk("ovf_count", 32'(if0.count), 32'd8);

      // Drain with registered read
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_data",  32'(if0.data_o), 32'(8'h10 + i));
         chk("drain_valid", 32'(if0.rd_valid), 32'd1);
         chk("drain_ae",    32'(if0.almost_empty), 32'(7 - i <= 2));
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("valid_drop", 32'(if0.rd_valid), 32'd0);
      chk("hold_data",  32'(if0.data_o), 32'h17);
      chk("drained",    32'(if0.empty), 32'd1);

      // Underflow and set/clear priority
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_set",   32'(if0.underflow), 32'd1);
      chk("udf_count", 32'(if0.count), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("udf_clr", 32'(if0.underflow), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      chk("udf_set_wins", 32'(if0.underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // Simultaneous read/write across pointer wrap
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
         exp5[i] = 8'(8'h30 + i);
      end
      for (int i = 0; i < 10; i++) exp5[4 + i] = 8'(8'h20 + i);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
         chk("rw_count", 32'(if0.count), 32'd4);
         chk("rw_data",  32'(if0.data_o), 32'(exp5[i]));
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("rw_tail", 32'(if0.data_o), 32'(exp5[10 + i]));
      end

      // FWFT: word visible the cycle after it is written into an empty FIFO
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("fwft_data",  32'(if1.data_o), 32'hAA);
      chk("fwft_valid", 32'(if1.rd_valid), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fwft_empty", 32'(if1.empty), 32'd1);
      chk("fwft_vdrop", 32'(if1.rd_valid), 32'd0);

      // Randomized traffic, biased so both full and empty are reached
      for (int i = 0; i < 600; i++) begin
         int phase;
         phase = (i / 100) % 2;
         cyc(1'(($urandom % 100) < (phase ? 30 : 70)), 8'($urandom),
             1'(($urandom % 100) < (phase ? 70 : 30)),
             1'(($urandom % 16) == 0));
      end

      // Asynchronous reset mid-stream with count 5
      for (int i = 0; i < 9 && if0.count != 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pre_rst_count", 32'(if0.count), 32'd5);
      chk("pre_rst_data",  32'(if0.data_o), 32'h55);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(if0.count), 32'd0);
      chk("rst_empty2", 32'(if0.empty), 32'd1);
      chk("rst_valid", 32'(if0.rd_valid), 32'd0);
      chk("rst_data",  32'(if0.data_o), 32'h00);
      chk("rst_valid1", 32'(if1.rd_valid), 32'd0);
      #8 rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
